// File: rtl/fifo_push_rr_arbiter_if.sv
// rtl/fifo_push_rr_arbiter_if.sv - producer/FIFO push-side bundle for fifo_push_rr_arbiter
interface fifo_push_rr_arbiter_if #(
    parameter int width = 8,
    parameter int n_req = 4
);
    localparam int idw = $clog2(n_req);

    logic [n_req-1:0]       req_valid;
    logic [n_req*width-1:0] req_data;
    logic [n_req-1:0]       req_ready;
    logic                   fifo_full;
    logic                   fifo_push;
    logic [width-1:0]       fifo_write_data;
    logic [idw-1:0]         grant_id;
    logic                   busy;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_push, fifo_write_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_push, fifo_write_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_push_rr_arbiter.sv
// rtl/fifo_push_rr_arbiter.sv - round-robin arbiter sharing one FIFO push port; ARB_BURST_EN enables multi-beat grants
module fifo_push_rr_arbiter #(
    parameter int width     = 8,
    parameter int n_req     = 4,
    parameter int max_burst = 4
) (
    input  logic clk,
    input  logic rst,
    fifo_push_rr_arbiter_if.master bus
);
    localparam int idw = $clog2(n_req);
    localparam logic [n_req-1:0] req_one = {{(n_req-1){1'b0}}, 1'b1};

    if (n_req < 2 || n_req > 16 || max_burst < 1 || max_burst > 255) begin : g_bad_params
        $error("fifo_push_rr_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q;
    logic [idw-1:0] grant_q;
    logic [idw-1:0] rr_q;
    logic [idw-1:0] rr_next;
    logic [idw-1:0] pick_id;
    logic           pick_found;
    logic [idw:0]   cand;
    logic           in_grant;
    logic           cur_valid;
    logic           last_beat;

    // Walk downward so the last hit is the first valid index at or after rr_q.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = n_req - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + (idw+1)'(k);
            if (cand >= (idw+1)'(n_req)) begin
                cand = cand - (idw+1)'(n_req);
            end
            if (bus.req_valid[cand[idw-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = cand[idw-1:0];
            end
        end
    end

    assign rr_next   = (grant_q == idw'(n_req - 1)) ? '0 : grant_q + idw'(1);
    assign in_grant  = (state_q == GRANT);
    assign cur_valid = bus.req_valid[grant_q];

    assign bus.req_ready       = (in_grant && !bus.fifo_full) ? (req_one << grant_q) : '0;
    assign bus.fifo_push       = in_grant && cur_valid && !bus.fifo_full;
    assign bus.fifo_write_data = bus.req_data[grant_q*width +: width];
    assign bus.grant_id        = grant_q;
    assign bus.busy            = in_grant;

`ifdef ARB_BURST_EN
    localparam int bw = $clog2(max_burst + 1);
    logic [bw-1:0] beat_q;
    assign last_beat = (beat_q == bw'(max_burst - 1));
`else
    assign last_beat = 1'b1;
`endif

    // A stalled beat (full with valid) holds everything; a dropped valid releases at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
`ifdef ARB_BURST_EN
            beat_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= GRANT;
                        grant_q <= pick_id;
`ifdef ARB_BURST_EN
                        beat_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!cur_valid || (!bus.fifo_full && last_beat)) begin
                        state_q <= IDLE;
                        rr_q    <= rr_next;
`ifdef ARB_BURST_EN
                        beat_q  <= '0;
`endif
                    end
`ifdef ARB_BURST_EN
                    else if (!bus.fifo_full) begin
                        beat_q <= beat_q + 1'b1;
                    end
`endif
                end
            endcase
        end
    end
endmodule
